up_down_counter_sequencer: RTL and testbench
============================================

# up_down_counter_sequencer

Controller that drives the clear, enable and direction inputs of a WIDTH-bit up/down counter and watches its count output. On a start command it clears the counter, counts up to a programmed target, and then either stops (single mode) or sweeps back down to zero for a programmed number of sweeps (ping-pong mode). Pause and abort controls are supported. It sits beside the up/down counter and replaces the hand-driven reset/up/en stimulus with a programmable sequence.

## Interface

Parameters:

- WIDTH, 3, counter width; also the width of target and cnt_in.
- SWEEP_W, 4, width of the sweeps request and the sweep_cnt status.

Ports (name, direction, width, meaning):

- clk, input, 1, single clock; all state changes on the rising edge.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, begin a sequence; sampled only in IDLE.
- mode, input, 1, 0 = single up-count, 1 = ping-pong; latched on start.
- target, input, WIDTH, terminal count; latched on start.
- sweeps, input, SWEEP_W, number of up/down sweeps in ping-pong mode; latched on start; 0 is treated as 1.
- pause, input, 1, holds the sequence while high.
- abort, input, 1, synchronous abort to IDLE.
- cnt_in, input, WIDTH, current counter value.
- cnt_clr, output, 1, counter clear; drives the counter's reset.
- cnt_en, output, 1, counter enable.
- cnt_up, output, 1, counter direction: 1 = up, 0 = down.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse on sequence completion.
- sweep_cnt, output, SWEEP_W, number of sweeps completed in the current sequence.

## Operation

States are IDLE, CLEAR, RUN_UP, RUN_DN and DONE.

- **IDLE**
  - start=1 latches tgt, mode and nsw (sweeps, or 1 if sweeps is 0), clears sweep_cnt, and moves to CLEAR.
  - start is ignored in every other state.
- **CLEAR**
  - cnt_clr=1 for exactly one cycle.
  - Next state is RUN_UP, or DONE if tgt==0.
- **RUN_UP**
  - cnt_up=1.
  - When advancing and cnt_in==tgt-1:
    - mode 0: go to DONE.
    - mode 1: go to RUN_DN.
- **RUN_DN**
  - cnt_up=0.
  - When advancing and cnt_in==1:
    - sweep_cnt increments.
    - If sweep_cnt+1==nsw, go to DONE; otherwise go to RUN_UP.
- **DONE**
  - done=1 for one cycle, then go to IDLE.
  - The counter holds its final value.

Output and control rules:

- "Advancing" means the state is RUN_UP or RUN_DN and pause=0 and abort=0.
- cnt_en = advancing. This is the only combinational output term.
- cnt_clr and cnt_up are decoded from the state register only. In IDLE and DONE, cnt_up keeps its last value.
- **Pause:** cnt_en is low and the state and sweep_cnt hold. Terminal checks are suppressed while paused. Releasing pause resumes with no lost or extra steps.
- **Abort:** from any non-IDLE state, go to IDLE on the next edge. done does not pulse. sweep_cnt keeps its value. abort has priority over pause and over terminal transitions. abort in IDLE is ignored.
- **Compare width:** compares are WIDTH-bit. tgt = 2^WIDTH-1 is legal. The counter never wraps under controller drive.

Reset (asynchronous): state=IDLE, cnt_clr=0, cnt_en=0, cnt_up=1, busy=0, done=0, sweep_cnt=0, and the latched registers are 0. Reset asserted mid-sequence aborts immediately; done does not pulse.

## Timing

- Call the edge that samples start E0.
  - CLEAR occupies cycle E0–E1.
  - RUN_UP begins at E1 with cnt_in=0.
  - The counter steps at each subsequent edge while cnt_en=1.
- **Single mode, target T≥1:** done is high in cycle E(T+1)–E(T+2). busy falls at E(T+2).
- **Ping-pong, T≥1, N sweeps:** done is high in cycle E(2TN+1)–E(2TN+2).
- **T=0:** done is high in cycle E1–E2. cnt_en never asserts.
- Each paused cycle delays all later events by one cycle.
- A new start is accepted at the earliest on the edge that ends the DONE cycle's successor, i.e. the first IDLE cycle.
- The counter is assumed to step on the same edge at which cnt_en is sampled high and to clear while cnt_clr=1.

## Test plan

1. **Reset:** assert reset mid-cycle during RUN_UP.
   - All outputs go to their reset values asynchronously.
   - After release, stay in IDLE with busy=0.
2. **Single mode:** target=5, mode=0, start.
   - cnt_clr pulses for 1 cycle.
   - cnt_en is high for 5 cycles and cnt_in runs 0→5.
   - done pulses at E6; counter holds 5.
3. **Ping-pong:** target=3, sweeps=2, mode=1.
   - cnt_in runs 0,1,2,3,2,1,0,1,2,3,2,1,0.
   - sweep_cnt ends at 2; done pulses at E13.
4. **Pause:** target=7, mode=0; pause high for 4 cycles when cnt_in=3.
   - cnt_in holds 3 for those 4 cycles.
   - done pulses at E12; no lost or extra steps.
5. **Abort:** target=6; abort when cnt_in=2.
   - Back in IDLE next edge; busy=0, done never pulses, counter holds 2.
   - A new start with target=1 completes at E2.
6. **Edge cases:**
   - target=0: done at E1, cnt_en never high.
   - target=7 (WIDTH=3), mode=1, sweeps=0: one sweep 0→7→0, done at E15.
   - start held high in DONE: ignored until IDLE.

Source files
------------

// File: rtl/up_down_counter_sequencer.sv
// rtl/up_down_counter_sequencer.sv - sequences clear/enable/direction of an up/down counter
// Single up-count or ping-pong sweeps to a latched target, with pause and abort.
module up_down_counter_sequencer #(
  parameter int WIDTH   = 3,
  parameter int SWEEP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   target,
  input  logic [SWEEP_W-1:0] sweeps,
  input  logic               pause,
  input  logic               abort,
  input  logic [WIDTH-1:0]   cnt_in,
  output logic               cnt_clr,
  output logic               cnt_en,
  output logic               cnt_up,
  output logic               busy,
  output logic               done,
  output logic [SWEEP_W-1:0] sweep_cnt
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN_UP, RUN_DN, DONE} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   tgt;
  logic               mode_q;
  logic [SWEEP_W-1:0] nsw;
  logic [SWEEP_W-1:0] sweep_nx;
  logic [SWEEP_W-1:0] sweep_inc;
  logic [WIDTH-1:0]   tgt_m1;
  logic               up_q, up_nx;
  logic               load;
  logic               advancing;

  assign advancing = ((state == RUN_UP) || (state == RUN_DN)) && !pause && !abort;
  assign tgt_m1    = tgt - WIDTH'(1);
  assign sweep_inc = sweep_cnt + SWEEP_W'(1);

  always_comb begin
    state_nx = state;
    sweep_nx = sweep_cnt;
    up_nx    = up_q;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          sweep_nx = '0;
          state_nx = CLEAR;
        end
      end
      CLEAR:  state_nx = (tgt == '0) ? DONE : RUN_UP;
      RUN_UP: begin
        if (advancing && (cnt_in == tgt_m1))
          state_nx = mode_q ? RUN_DN : DONE;
      end
      RUN_DN: begin
        if (advancing && (cnt_in == WIDTH'(1))) begin
          sweep_nx = sweep_inc;
          state_nx = (sweep_inc == nsw) ? DONE : RUN_UP;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // abort outranks pause and terminal transitions; advancing is already low
    if (abort && (state != IDLE))
      state_nx = IDLE;
    case (state_nx)
      CLEAR, RUN_UP: up_nx = 1'b1;
      RUN_DN:        up_nx = 1'b0;
      default:       up_nx = up_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tgt       <= '0;
      mode_q    <= 1'b0;
      nsw       <= '0;
      sweep_cnt <= '0;
      up_q      <= 1'b1;
    end else begin
      state     <= state_nx;
      sweep_cnt <= sweep_nx;
      up_q      <= up_nx;
      if (load) begin
        tgt    <= target;
        mode_q <= mode;
        nsw    <= (sweeps == '0) ? SWEEP_W'(1) : sweeps;
      end
    end
  end

  assign cnt_clr = (state == CLEAR);
  assign cnt_en  = advancing;
  assign cnt_up  = up_q;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_up_down_counter_sequencer.sv
// tb/tb_up_down_counter_sequencer.sv - directed vector bench for up_down_counter_sequencer
// A behavioural 3-bit up/down counter closes the loop around the sequencer.
module tb_up_down_counter_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, mode, pause, abort;
  logic [2:0] target;
  logic [3:0] sweeps;
  logic [2:0] cnt_in = 3'd0;
  logic       cnt_clr, cnt_en, cnt_up, busy, done;
  logic [3:0] sweep_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int trace[$];

  typedef struct {
    logic mode;
    int   target;
    int   sweeps;
    int   pause_at;
    int   pause_len;
    int   exp_done;
    int   exp_en;
    int   exp_final;
    int   exp_sweep;
  } vec_t;

  vec_t vecs[8];

  up_down_counter_sequencer #(.WIDTH(3), .SWEEP_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .target(target),
    .sweeps(sweeps), .pause(pause), .abort(abort), .cnt_in(cnt_in),
    .cnt_clr(cnt_clr), .cnt_en(cnt_en), .cnt_up(cnt_up), .busy(busy),
    .done(done), .sweep_cnt(sweep_cnt)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (cnt_clr)     cnt_in <= 3'd0;
    else if (cnt_en) cnt_in <= cnt_up ? cnt_in + 3'd1 : cnt_in - 3'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_seq(input string tag, input vec_t v);
    int  done_at = -1;
    int  en_n = 0, clr_n = 0, held = 0, pause_left = 0;
    bit  pause_used = 0;
    trace.delete();
    @(negedge clk);
    mode = v.mode; target = 3'(v.target); sweeps = 4'(v.sweeps); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 100 && done_at < 0; k++) begin
      @(negedge clk);
      if (pause_left > 0) begin
        pause_left--;
        if (pause_left == 0) pause = 1'b0;
      end
      if (!pause_used && v.pause_len > 0 && busy && !cnt_clr && cnt_in == 3'(v.pause_at)) begin
        pause = 1'b1; pause_left = v.pause_len; pause_used = 1;
      end
      en_n  += int'(cnt_en);
      clr_n += int'(cnt_clr);
      if (pause && cnt_in == 3'(v.pause_at)) held++;
      if (busy && !cnt_clr && !done) trace.push_back(int'(cnt_in));
      @(posedge clk);
      #1;
      if (done) done_at = k;
    end
    pause = 1'b0;
    chk({tag, "_done_edge"}, done_at, v.exp_done);
    chk({tag, "_en_cycles"}, en_n, v.exp_en);
    chk({tag, "_clr_cycles"}, clr_n, 1);
    chk({tag, "_final_cnt"}, int'(cnt_in), v.exp_final);
    chk({tag, "_sweep_cnt"}, int'(sweep_cnt), v.exp_sweep);
    chk({tag, "_pause_hold"}, held, v.pause_len);
    @(posedge clk);
    #1;
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_idle_done"}, int'(done), 0);
  endtask

  initial begin
    int   found;
    int   bad;
    int   seen_done;
    int   pp_exp[12];
    vec_t pp;

    vecs[0] = '{1'b0, 5, 0, 0, 0,  6,  5, 5, 0};
    vecs[1] = '{1'b0, 7, 0, 3, 4, 12,  7, 7, 0};
    vecs[2] = '{1'b0, 0, 0, 0, 0,  1,  0, 0, 0};
    vecs[3] = '{1'b1, 7, 0, 0, 0, 15, 14, 0, 1};
    vecs[4] = '{1'b1, 2, 3, 0, 0, 13, 12, 0, 3};
    vecs[5] = '{1'b1, 0, 5, 0, 0,  1,  0, 0, 0};
    vecs[6] = '{1'b0, 1, 0, 0, 0,  2,  1, 1, 0};
    vecs[7] = '{1'b1, 1, 1, 0, 0,  3,  2, 0, 1};
    pp      = '{1'b1, 3, 2, 0, 0, 13, 12, 0, 2};
    pp_exp  = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1};

    reset = 1'b1; start = 1'b0; mode = 1'b0; target = 3'd0; sweeps = 4'd0;
    pause = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt_up", int'(cnt_up), 1);
    chk("rst_cnt_en", int'(cnt_en), 0);
    reset = 1'b0;

    foreach (vecs[i]) run_seq($sformatf("vec%0d", i), vecs[i]);

    // ping-pong: full counter trajectory
    run_seq("pingpong", pp);
    chk("pp_trace_len", trace.size(), 12);
    bad = 0;
    for (int i = 0; i < 12 && i < trace.size(); i++) if (trace[i] != pp_exp[i]) bad++;
    chk("pp_trace_mismatches", bad, 0);

    // asynchronous reset mid-sequence during the second RUN_UP sweep
    @(negedge clk);
    mode = 1'b1; target = 3'd3; sweeps = 4'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (sweep_cnt == 4'd1 && cnt_up && cnt_in == 3'd2) found = 1;
    end
    chk("rst_reach_run_up", found, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_cnt_en", int'(cnt_en), 0);
    chk("arst_cnt_clr", int'(cnt_clr), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_cnt_up", int'(cnt_up), 1);
    chk("arst_sweep_cnt", int'(sweep_cnt), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("post_rst_busy", int'(busy), 0);

    // abort at cnt_in=2, then a fresh target=1 sequence
    @(negedge clk);
    mode = 1'b0; target = 3'd6; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (busy && !cnt_clr && cnt_in == 3'd2) found = 1;
    end
    chk("abort_reach_2", found, 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", int'(busy), 0);
    abort = 1'b0;
    seen_done = 0;
    repeat (5) begin
      @(posedge clk);
      #1 seen_done += int'(done);
    end
    chk("abort_no_done", seen_done, 0);
    chk("abort_cnt_hold", int'(cnt_in), 2);
    run_seq("after_abort", vecs[6]);

    // start held through DONE is only taken in the following IDLE cycle
    @(negedge clk);
    mode = 1'b0; target = 3'd2; start = 1'b1;
    @(posedge clk);
    found = 0;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(posedge clk);
      #1 if (done) found = k;
    end
    chk("held_done_edge", found, 3);
    @(posedge clk);
    #1 chk("held_idle_busy", int'(busy), 0);
    @(posedge clk);
    #1 chk("held_restart_clr", int'(cnt_clr), 1);
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk);
      #1 if (done) found = 1;
    end
    chk("held_second_done", found, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
